// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong game-sequencing controller.
//   - state_t       : FSM state encoding (NEWGAME/PLAY/NEWBALL/OVER)
//   - BCD_W         : width of one BCD score digit
//   - TIMER_W       : width of the post-miss pause timer
//   - DEF_*         : default values for the top-level parameters
//   - bcd_digit_inc : one-digit BCD increment returning {carry, digit}
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam int BCD_W           = 4;
  localparam int TIMER_W         = 7;
  localparam int DEF_BALL_LIVES  = 3;
  localparam int DEF_TIMER_TICKS = 120;

  // Increment a single BCD digit; bit BCD_W is the carry into the next digit.
  function automatic logic [BCD_W:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
    logic [BCD_W:0] r;
    if (d == 4'd9) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_bcd2_counter.sv
// pong_bcd2_counter: two-digit BCD counter (00..99, wraps 99 -> 00).
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low reset (clears to 00)
//   clr_i   in  1  synchronous clear, priority over inc_i
//   inc_i   in  1  count up by one
//   dig1_o  out 4  tens digit
//   dig0_o  out 4  units digit
module pong_bcd2_counter
  import pong_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] dig1_o,
  output logic [BCD_W-1:0] dig0_o
);

  logic [BCD_W-1:0] dig1_q, dig1_d;
  logic [BCD_W-1:0] dig0_q, dig0_d;
  logic [BCD_W:0]   inc0_s, inc1_s;

  // Next-value logic: clear wins, otherwise ripple a units carry into tens.
  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    inc0_s = bcd_digit_inc(dig0_q);
    inc1_s = bcd_digit_inc(dig1_q);
    if (clr_i) begin
      dig1_d = 4'd0;
      dig0_d = 4'd0;
    end else if (inc_i) begin
      dig0_d = inc0_s[BCD_W-1:0];
      if (inc0_s[BCD_W]) begin
        // Tens carry-out is dropped, giving the 99 -> 00 wrap.
        dig1_d = inc1_s[BCD_W-1:0];
      end else begin
        dig1_d = dig1_q;
      end
    end else begin
      dig1_d = dig1_q;
      dig0_d = dig0_q;
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else begin
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
    end
  end

  assign dig1_o = dig1_q;
  assign dig0_o = dig0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-sequencing controller for the pong graphics datapath.
// Freezes/animates the ball, counts spare balls, keeps a 2-digit BCD score
// and times the pause after a miss.
// Parameters:
//   BALL_LIVES   balls per game (1..3)
//   TIMER_TICKS  refresh ticks in the post-miss pause (1..127)
// Ports:
//   clk         in  1  system pixel clock
//   reset       in  1  asynchronous active-low reset
//   btn         in  2  paddle buttons (any bit high = press)
//   refr_tick   in  1  1-clk pulse at start of vsync
//   hit         in  1  1-clk pulse, ball bounced off paddle
//   miss        in  1  1-clk pulse, ball passed paddle
//   gra_still   out 1  ball held at start position
//   state       out 2  current FSM state (pong_pkg encoding)
//   balls_left  out 2  spare balls not yet served
//   score1/0    out 4  BCD score tens/units
//   timer_done  out 1  pause timer is zero
//   hi1/hi0     out 4  BCD high score (only with PONG_HISCORE_EN defined)
// Build option: define PONG_HISCORE_EN to add the high-score registers.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_LIVES  = DEF_BALL_LIVES,
  parameter int TIMER_TICKS = DEF_TIMER_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       btn,
  input  logic             refr_tick,
  input  logic             hit,
  input  logic             miss,
  output logic             gra_still,
  output logic [1:0]       state,
  output logic [1:0]       balls_left,
  output logic [BCD_W-1:0] score1,
  output logic [BCD_W-1:0] score0,
  output logic             timer_done
`ifdef PONG_HISCORE_EN
  ,
  output logic [BCD_W-1:0] hi1,
  output logic [BCD_W-1:0] hi0
`endif
);

  localparam logic [1:0]         LIVES = 2'(BALL_LIVES);
  localparam logic [TIMER_W-1:0] TICKS = TIMER_W'(TIMER_TICKS);

  state_t             state_q, state_d;
  logic [1:0]         balls_q, balls_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timer_done_s;
  logic               btn_press_s;
  logic               score_clr_s;
  logic               score_inc_s;

  assign timer_done_s = (timer_q == 7'd0);
  assign btn_press_s  = (btn != 2'b00);

  // Next-state, spare-ball, pause-timer and score-control decode.
  always_comb begin
    state_d     = state_q;
    balls_d     = balls_q;
    score_clr_s = 1'b0;
    score_inc_s = 1'b0;
    // Free-running pause countdown; a miss load below overrides it.
    if (refr_tick && !timer_done_s) begin
      timer_d = timer_q - 7'd1;
    end else begin
      timer_d = timer_q;
    end
    case (state_q)
      ST_NEWGAME: begin
        score_clr_s = 1'b1;
        balls_d     = LIVES;
        if (btn_press_s) begin
          state_d = ST_PLAY;
          balls_d = LIVES - 2'd1;
        end else begin
          state_d = ST_NEWGAME;
        end
      end
      ST_PLAY: begin
        if (miss) begin
          // Miss beats a same-cycle hit: score is left alone.
          timer_d = TICKS;
          if (balls_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_NEWBALL;
            balls_d = balls_q - 2'd1;
          end
        end else if (hit) begin
          score_inc_s = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_NEWBALL: begin
        // A button held through the pause serves as soon as the timer ends.
        if (timer_done_s && btn_press_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_NEWBALL;
        end
      end
      ST_OVER: begin
        if (timer_done_s) begin
          // Clear on the way out so NEWGAME is entered already showing 00.
          state_d     = ST_NEWGAME;
          balls_d     = LIVES;
          score_clr_s = 1'b1;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d     = ST_NEWGAME;
        balls_d     = LIVES;
        timer_d     = 7'd0;
        score_clr_s = 1'b1;
      end
    endcase
  end

  // FSM, spare-ball and timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_NEWGAME;
      balls_q <= LIVES;
      timer_q <= 7'd0;
    end else begin
      state_q <= state_d;
      balls_q <= balls_d;
      timer_q <= timer_d;
    end
  end

  pong_bcd2_counter u_score (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (score_clr_s),
    .inc_i  (score_inc_s),
    .dig1_o (score1),
    .dig0_o (score0)
  );

`ifdef PONG_HISCORE_EN
  logic [BCD_W-1:0] hi1_q, hi0_q;

  // High score: capture on the final miss of a game if it beats the record.
  // Packed BCD digits compare correctly as an unsigned 8-bit value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi1_q <= 4'd0;
      hi0_q <= 4'd0;
    end else if ((state_q == ST_PLAY) && miss && (balls_q == 2'd0) &&
                 ({score1, score0} > {hi1_q, hi0_q})) begin
      hi1_q <= score1;
      hi0_q <= score0;
    end else begin
      hi1_q <= hi1_q;
      hi0_q <= hi0_q;
    end
  end

  assign hi1 = hi1_q;
  assign hi0 = hi0_q;
`endif

  assign state      = state_q;
  assign balls_left = balls_q;
  assign gra_still  = (state_q != ST_PLAY);
  assign timer_done = timer_done_s;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl (default parameters: 3 balls,
// 120-tick pause). Also exercises the high score when PONG_HISCORE_EN is set.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic       refr_tick, hit, miss;
  logic       gra_still, timer_done;
  logic [1:0] state, balls_left;
  logic [3:0] score1, score0;
`ifdef PONG_HISCORE_EN
  logic [3:0] hi1, hi0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .refr_tick  (refr_tick),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .state      (state),
    .balls_left (balls_left),
    .score1     (score1),
    .score0     (score0),
    .timer_done (timer_done)
`ifdef PONG_HISCORE_EN
    ,
    .hi1        (hi1),
    .hi0        (hi0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hits(input int n);
    hit = 1'b1;
    tick(n);
    hit = 1'b0;
  endtask

  task automatic pulse_miss();
    miss = 1'b1;
    tick(1);
    miss = 1'b0;
  endtask

  task automatic press();
    btn = 2'b01;
    tick(1);
    btn = 2'b00;
  endtask

  task automatic expire_timer();
    refr_tick = 1'b1;
    tick(120);
    refr_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0; btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_balls", balls_left, 3);
    chk("rst_score1", score1, 0);
    chk("rst_score0", score0, 0);
    chk("rst_timer_done", timer_done, 1);
    chk("rst_gra_still", gra_still, 1);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    chk("newgame_idle", state, 0);

    // Hit outside PLAY is ignored.
    hits(1);
    chk("newgame_hit_ignored", score0, 0);

    // Serve: NEWGAME -> PLAY, one ball used.
    press();
    chk("serve_state", state, 1);
    chk("serve_balls", balls_left, 2);
    chk("serve_gra_still", gra_still, 0);

    // BCD scoring and wrap.
    hits(9);
    chk("score09_tens", score1, 0);
    chk("score09_units", score0, 9);
    hits(1);
    chk("score10_tens", score1, 1);
    chk("score10_units", score0, 0);
    hits(89);
    chk("score99_tens", score1, 9);
    chk("score99_units", score0, 9);
    hits(1);
    chk("wrap_tens", score1, 0);
    chk("wrap_units", score0, 0);
    hits(5);

    // Hit + miss + refr_tick together: miss wins, timer loads full.
    hit = 1'b1; miss = 1'b1; refr_tick = 1'b1;
    tick(1);
    hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    chk("hitmiss_state", state, 2);
    chk("hitmiss_balls", balls_left, 1);
    chk("hitmiss_score", score0, 5);
    chk("hitmiss_timer_done", timer_done, 0);
    chk("newball_gra_still", gra_still, 1);

    // Pause: button pressed from tick 60 and held; served after tick 120.
    for (int k = 1; k <= 120; k++) begin
      refr_tick = 1'b1;
      tick(1);
      refr_tick = 1'b0;
      if (k == 119) begin
        chk("tick119_done", timer_done, 0);
        chk("tick119_state", state, 2);
      end
      if (k == 120) begin
        chk("tick120_done", timer_done, 1);
        chk("tick120_state", state, 2);
      end
      if (k == 31) chk("newball_hit_ignored", score0, 5);
      if (k == 30) hit = 1'b1;
      if (k == 60) btn = 2'b10;
      tick(1);
      hit = 1'b0;
    end
    chk("held_btn_serve", state, 1);
    chk("held_btn_balls", balls_left, 1);
    btn = 2'b00;

    // Last spare ball.
    pulse_miss();
    chk("miss2_state", state, 2);
    chk("miss2_balls", balls_left, 0);
    expire_timer();
    chk("miss2_expired", timer_done, 1);
    press();
    chk("last_serve", state, 1);
    hits(37);
    chk("score42_tens", score1, 4);
    chk("score42_units", score0, 2);

    // Final miss -> OVER; score kept on entry, no ball underflow.
    pulse_miss();
    chk("over_state", state, 3);
    chk("over_balls", balls_left, 0);
    chk("over_score_kept", score1, 4);
    chk("over_gra_still", gra_still, 1);
`ifdef PONG_HISCORE_EN
    chk("hi_first_tens", hi1, 4);
    chk("hi_first_units", hi0, 2);
`endif
    refr_tick = 1'b1;
    tick(119);
    refr_tick = 1'b0;
    chk("over119_done", timer_done, 0);
    chk("over119_state", state, 3);
    refr_tick = 1'b1;
    tick(1);
    refr_tick = 1'b0;
    chk("over120_done", timer_done, 1);
    tick(1);
    chk("regame_state", state, 0);
    chk("regame_score1", score1, 0);
    chk("regame_score0", score0, 0);
    chk("regame_balls", balls_left, 3);

    // Second game ending at 15.
    press();
    hits(15);
    pulse_miss();
    expire_timer();
    press();
    pulse_miss();
    expire_timer();
    press();
    pulse_miss();
    chk("game2_over", state, 3);
    chk("game2_score0", score0, 5);
`ifdef PONG_HISCORE_EN
    chk("hi_kept_tens", hi1, 4);
    chk("hi_kept_units", hi0, 2);
`endif
    expire_timer();
    tick(1);
    chk("game2_newgame", state, 0);

    // Third game: asynchronous reset mid-PLAY at score 37.
    press();
    hits(37);
    chk("score37_tens", score1, 3);
    chk("score37_units", score0, 7);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_balls", balls_left, 3);
    chk("arst_score1", score1, 0);
    chk("arst_score0", score0, 0);
    chk("arst_timer_done", timer_done, 1);
    chk("arst_gra_still", gra_still, 1);
`ifdef PONG_HISCORE_EN
    chk("arst_hi1", hi1, 0);
    chk("arst_hi0", hi0, 0);
`endif
    tick(1);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    chk("post_arst_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the pong graphics datapath: decides when the ball is frozen or animating, counts remaining balls, keeps a 2-digit BCD score, and times the pause after a miss.
- Sits between the button inputs and the graphics/animation block; consumes that block's hit/miss pulses and the 60 Hz refresh tick; drives its freeze control and the score/status text overlay.

Parameters:
- BALL_LIVES, 3, balls per game (1..3).
- TIMER_TICKS, 120, refresh ticks in the post-miss pause (2 s at 60 Hz; 1..127).

Ports:
- clk  in  1  system pixel clock.
- reset  in  1  asynchronous, active-low reset.
- btn  in  2  paddle buttons, level, synchronous to clk; any bit high = "press".
- refr_tick  in  1  1-clk pulse at start of vsync.
- hit  in  1  1-clk pulse: ball bounced off paddle.
- miss  in  1  1-clk pulse: ball passed paddle.
- gra_still  out  1  1 = ball held at start position, no animation.
- state  out  2  current FSM state (pkg encoding).
- balls_left  out  2  spare balls not yet served.
- score1, score0  out  4 each  BCD tens/units.
- timer_done  out  1  pause timer is zero.

Behaviour:
- Reset (async, reset=0): state=NEWGAME, balls_left=BALL_LIVES, score=00, timer=0, timer_done=1, gra_still=1. Takes effect mid-game immediately; first post-release edge evaluates NEWGAME.
- All state registered on posedge clk; outputs decoded from registers only (no input-to-output comb paths).
- NEWGAME (00): gra_still=1; score held at 00, balls_left=BALL_LIVES. btn!=0 -> PLAY next cycle, balls_left decrements by 1 on that edge.
- PLAY (01): gra_still=0. hit -> score +1 BCD (09->10, 99->00 wrap). miss -> timer loads TIMER_TICKS; if balls_left==0 -> OVER, else -> NEWBALL with balls_left-1.
- NEWBALL (10): gra_still=1; when timer_done && btn!=0 -> PLAY. Button held from before pause still counts once timer expires.
- OVER (11): gra_still=1; when timer_done -> NEWGAME (score cleared there, not on OVER entry).
- Timer: 7-bit down-counter; decrements on refr_tick when non-zero; load has priority over a same-cycle refr_tick; timer_done = (timer==0).
- hit and miss in same cycle in PLAY: miss processed, hit ignored (score unchanged).
- hit/miss outside PLAY: ignored. refr_tick has no effect other than timer.
- balls_left never underflows: decrement only when non-zero.

Optional Feature:
- Macro PONG_HISCORE_EN.
- Defined: adds outputs hi1, hi0 (4 bits each, BCD). On the PLAY->OVER transition, if {score1,score0} > {hi1,hi0}, hi registers load the score. Cleared only by reset.
- Undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Package pong_pkg: state encodings (NEWGAME=2'b00, PLAY=2'b01, NEWBALL=2'b10, OVER=2'b11), BCD digit width (4), and defaults for BALL_LIVES and TIMER_TICKS.
- One sub-module: pong_bcd2_counter, a 2-digit BCD counter with clr, inc, and async active-low reset; instantiated for the score.

Test Plan:
- Reset, then btn=01 for 1 clk -> state 00->01 next edge, balls_left 3->2, gra_still 1->0.
- In PLAY, 10 hit pulses -> score 1,0. Then 90 more -> 0,0 (wrap).
- In PLAY with balls_left=2, miss -> NEWBALL, balls_left=1, timer=120. Assert btn at tick 60 and hold it -> stays NEWBALL. After the 120th refr_tick -> PLAY on next clk.
- In PLAY with balls_left=0, miss -> OVER. After 120 refr_ticks -> NEWGAME, score=00, balls_left=3.
- In PLAY, hit and miss in the same cycle -> score unchanged, state NEWBALL. Miss and refr_tick in the same cycle -> timer=120.
- Drive reset=0 asynchronously mid-PLAY with score 37 -> outputs return to reset values before the next clk edge. With PONG_HISCORE_EN, a game ending at 42 then one ending at 15 -> hi stays 4,2.
